sram_req_ctrl: RTL and testbench

- Request-side controller placed directly upstream of the synchronous single-port SRAM (CS/WR/RD strobes, registered read data).
- Converts a valid/ready request stream (read or write) into correctly timed SRAM strobes.
- Captures SRAM read data and returns it on a valid/ready response channel.
- Rejects out-of-range addresses with an error flag, so the SRAM is never strobed for them.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_req_ctrl_if.sv | 30 +++
 rtl/sram_req_ctrl.sv | 118 +++++++++++
 tb/tb_sram_req_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM request controller and the SRAM it drives.
package sram_pkg;

  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_DEPTH      = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response channels of the SRAM request controller.
// Handshake: a beat transfers on a rising edge where valid && ready; valid and
// its payload stay stable until that edge, and ready never depends on valid.
interface sram_req_ctrl_if #(
  parameter int DATA_WIDTH = sram_pkg::SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_pkg::SRAM_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_req_ctrl.sv
// Turns a valid/ready read/write request stream into registered SRAM strobes
// and returns read data on a valid/ready response channel.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DEPTH      = SRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_req_ctrl_if.slave        bus,
  output logic                  mem_cs,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output state_t                dbg_state
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  state_t state_q, state_d;

  logic                  accept;
  logic                  in_range;
  logic                  mem_cs_d, mem_wr_d, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  assign in_range = {1'b0, bus.req_addr} < DEPTH_LIM;
  assign accept   = bus.req_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_range)         state_d = bus.req_wr ? WRITE : READ;
          else if (!bus.req_wr) state_d = RESP;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    mem_cs_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_rd_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept && in_range) begin
          mem_cs_d   = 1'b1;
          mem_addr_d = bus.req_addr;
          if (bus.req_wr) begin
            mem_wr_d    = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else begin
            mem_rd_d = 1'b1;
          end
        end else if (accept && !bus.req_wr) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      CAPT: begin
        rsp_rdata_d = mem_rdata;
        rsp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      mem_cs      <= mem_cs_d;
      mem_wr      <= mem_wr_d;
      mem_rd      <= mem_rd_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural SRAM (DEPTH=200).
module tb_sram_req_ctrl;
  import sram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_cs, mem_wr, mem_rd;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  state_t     dbg_state;

  logic [7:0] sram [0:255];
  logic [7:0] exp_q[$];

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int viol     = 0;

  sram_req_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  sram_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data registered one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_cs && mem_wr) sram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_rd) mem_rdata <= sram[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr && mem_rd) viol++;
      if (mem_cs != (mem_wr ^ mem_rd)) viol++;
      if (mem_cs && mem_wr) wr_cnt++;
      if (mem_cs && mem_rd) rd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    bit acc = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("req_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic stream_read(input logic [7:0] a);
    bit done = 0;
    logic [7:0] exp;
    issue(1'b0, a, 8'h00);
    for (int c = 0; c < 60 && !done; c++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp = exp_q.pop_front();
        check("stream_rdata", 32'(bus.rsp_rdata), 32'(exp));
        check("stream_err", 32'(bus.rsp_err), 32'd0);
        done = 1;
      end
      tick();
    end
    check("stream_rsp_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int w0, r0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_mem_strb",  32'({mem_cs, mem_wr, mem_rd}), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));

    // Single write 0xA5 -> 0x10
    w0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h10; bus.req_wdata = 8'hA5;
    tick();
    bus.req_valid = 1'b0;
    check("wr1_strb",      32'({mem_cs, mem_wr, mem_rd}), 32'b110);
    check("wr1_addr",      32'(mem_addr),  32'h10);
    check("wr1_wdata",     32'(mem_wdata), 32'hA5);
    check("wr1_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("wr1_strb_clr",  32'({mem_cs, mem_wr, mem_rd}), 32'd0);
    check("wr1_ready_back", 32'(bus.req_ready), 32'd1);
    check("wr1_sram",      32'(sram[8'h10]), 32'hA5);
    check("wr1_one_strobe", 32'(wr_cnt - w0), 32'd1);

    // Write 0x3C -> 0x05 then immediate read of 0x05
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h05; bus.req_wdata = 8'h3C;
    tick();
    bus.req_wr = 1'b0;
    check("wr2_busy", 32'(bus.req_ready), 32'd0);
    tick();
    check("rd2_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("rd2_strb", 32'({mem_cs, mem_wr, mem_rd}), 32'b101);
    check("rd2_addr", 32'(mem_addr), 32'h05);
    check("rd2_n1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rd2_n2_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rd2_n3_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd2_rdata",    32'(bus.rsp_rdata), 32'h3C);
    check("rd2_err",      32'(bus.rsp_err),   32'd0);
    tick();
    check("rd2_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd2_done_ready", 32'(bus.req_ready), 32'd1);

    // Backpressure: rsp_ready low for 10 cycles
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h05;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    w0 = wr_cnt; r0 = rd_cnt;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h20; bus.req_wdata = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", 32'(bus.rsp_rdata), 32'h3C);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    check("bp_no_strobe", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);

    // Out-of-range write and read at 0xC8 (DEPTH=200)
    w0 = wr_cnt; r0 = rd_cnt;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'hC8; bus.req_wdata = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    check("oor_wr_cs",    32'(mem_cs), 32'd0);
    check("oor_wr_ready", 32'(bus.req_ready), 32'd1);
    check("oor_wr_state", 32'(dbg_state), 32'(IDLE));
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'hC8;
    tick();
    bus.req_valid = 1'b0;
    check("oor_rd_valid", 32'(bus.rsp_valid), 32'd1);
    check("oor_rd_rdata", 32'(bus.rsp_rdata), 32'h00);
    check("oor_rd_err",   32'(bus.rsp_err),   32'd1);
    check("oor_rd_cs",    32'(mem_cs), 32'd0);
    tick();
    check("oor_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("oor_no_strobe",  32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

    // Reset during CAPT
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h05;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("mid_state_capt", 32'(dbg_state), 32'(CAPT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_mem_strb",  32'({mem_cs, mem_wr, mem_rd}), 32'd0);
    check("mid_mem_addr",  32'(mem_addr), 32'd0);
    check("mid_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Streaming write/read pairs with random rsp_ready
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      a = 8'(i);
      issue(1'b1, a, a ^ 8'hFF);
      exp_q.push_back(a ^ 8'hFF);
      stream_read(a);
    end
    bus.rsp_ready = 1'b1;
    check("stream_wr_strobes", 32'(wr_cnt - w0), 32'd16);
    check("stream_rd_strobes", 32'(rd_cnt - r0), 32'd16);
    check("stream_q_empty",    32'(exp_q.size()), 32'd0);
    check("strobe_invariant",  32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
